// File: rtl/packet_framer_if.sv
// Handshake bundle between the packet framer and its environment:
// command channel, raw payload stream and framed output beats.
interface packet_framer_if;
  logic        cmd_val;
  logic        cmd_ready;
  logic [15:0] cmd_stream;
  logic [15:0] cmd_length;
  logic        cmd_skip;
  logic        cmd_err;
  logic [31:0] pay_data;
  logic        pay_val;
  logic        pay_ready;
  logic [31:0] dataOut;
  logic        dataOut_val;
  logic        dataOut_ready;
  logic        dataOut_last;

  // environment side: issues commands and payload, consumes framed beats
  modport master (
    output cmd_val, cmd_stream, cmd_length, cmd_skip, pay_data, pay_val, dataOut_ready,
    input  cmd_ready, cmd_err, pay_ready, dataOut, dataOut_val, dataOut_last
  );

  // framer side
  modport slave (
    input  cmd_val, cmd_stream, cmd_length, cmd_skip, pay_data, pay_val, dataOut_ready,
    output cmd_ready, cmd_err, pay_ready, dataOut, dataOut_val, dataOut_last
  );
endinterface

// File: rtl/packet_framer.sv
// Packet framer: prepends an 8-byte little-endian header (length, stream,
// per-stream sequence number) to a raw payload word stream.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | accepting commands; error/skip commands are handled in place
// HDR0  | presenting header word0 (length, stream)
// HDR1  | presenting header word1 (sequence); counter bumps on transfer
// PAY   | payload passes straight through until the last payload beat
module packet_framer #(
  parameter int          NUM_STREAMS = 16,
  parameter logic [31:0] SEQ_INIT    = 32'h0000_0001
) (
  input logic            clk,
  input logic            reset_b,
  packet_framer_if.slave bus
);

  localparam int          SW = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
  localparam logic [16:0] NS = 17'(NUM_STREAMS);

  typedef enum logic [1:0] {IDLE, HDR0, HDR1, PAY} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] seq_cnt [NUM_STREAMS];
  logic [15:0] stream_q;
  logic [15:0] length_q;
  logic [31:0] seq_q;
  logic [SW-1:0] sidx_q;
  logic [13:0] pay_cnt;
  logic        cmd_err_q;

  logic [SW-1:0] cmd_sidx;
  logic        cmd_fire;
  logic        stream_ok;
  logic        len_ok;
  logic        is_err;
  logic        is_skip;
  logic        is_send;
  logic        hdr1_fire;
  logic        pay_fire;
  logic        single_hdr;

  assign cmd_sidx   = bus.cmd_stream[SW-1:0];
  assign stream_ok  = {1'b0, bus.cmd_stream} < NS;
  assign len_ok     = bus.cmd_length >= 16'd8;
  // commands are only taken in IDLE; reset gating of cmd_ready is cosmetic
  // since all state is held in reset anyway
  assign cmd_fire   = bus.cmd_val && (state == IDLE);
  assign is_err     = cmd_fire && (!stream_ok || (!bus.cmd_skip && !len_ok));
  assign is_skip    = cmd_fire && stream_ok && bus.cmd_skip;
  assign is_send    = cmd_fire && stream_ok && !bus.cmd_skip && len_ok;
  assign single_hdr = (length_q[15:2] == 14'd2);
  assign hdr1_fire  = (state == HDR1) && bus.dataOut_ready;
  assign pay_fire   = (state == PAY) && bus.pay_val && bus.dataOut_ready;

  assign bus.cmd_ready = (state == IDLE) && reset_b;
  assign bus.cmd_err   = cmd_err_q;

  // state register
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state <= IDLE;
    else          state <= state_nxt;
  end

  // next state and beat outputs
  always_comb begin
    state_nxt        = state;
    bus.dataOut      = 32'h0;
    bus.dataOut_val  = 1'b0;
    bus.dataOut_last = 1'b0;
    bus.pay_ready    = 1'b0;
    case (state)
      IDLE: begin
        if (is_send) state_nxt = HDR0;
      end
      HDR0: begin
        bus.dataOut     = {length_q[7:0], length_q[15:8], stream_q[7:0], stream_q[15:8]};
        bus.dataOut_val = 1'b1;
        if (bus.dataOut_ready) state_nxt = HDR1;
      end
      HDR1: begin
        bus.dataOut      = {seq_q[7:0], seq_q[15:8], seq_q[23:16], seq_q[31:24]};
        bus.dataOut_val  = 1'b1;
        bus.dataOut_last = single_hdr;
        if (bus.dataOut_ready) state_nxt = single_hdr ? IDLE : PAY;
      end
      PAY: begin
        bus.dataOut      = bus.pay_data;
        bus.dataOut_val  = bus.pay_val;
        bus.pay_ready    = bus.dataOut_ready;
        bus.dataOut_last = (pay_cnt == 14'd1);
        if (pay_fire && (pay_cnt == 14'd1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // command latch, payload beat countdown and error pulse
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      stream_q  <= 16'h0;
      length_q  <= 16'h0;
      seq_q     <= 32'h0;
      sidx_q    <= '0;
      pay_cnt   <= 14'h0;
      cmd_err_q <= 1'b0;
    end else begin
      cmd_err_q <= is_err;
      if (is_send) begin
        stream_q <= bus.cmd_stream;
        length_q <= bus.cmd_length;
        seq_q    <= seq_cnt[cmd_sidx];
        sidx_q   <= cmd_sidx;
        pay_cnt  <= bus.cmd_length[15:2] - 14'd2;
      end else if (pay_fire) begin
        pay_cnt <= pay_cnt - 14'd1;
      end
    end
  end

  // per-stream sequence counters; skip and word1 transfer never coincide
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < NUM_STREAMS; i++) seq_cnt[i] <= SEQ_INIT;
    end else begin
      if (is_skip)   seq_cnt[cmd_sidx] <= seq_cnt[cmd_sidx] + 32'd1;
      if (hdr1_fire) seq_cnt[sidx_q]   <= seq_cnt[sidx_q] + 32'd1;
    end
  end

endmodule

// File: tb/tb_packet_framer.sv
// Bench for packet_framer: scoreboard of expected beats filled when commands
// are issued, drained by a monitor sampling on the falling edge.
module tb_packet_framer;

  logic clk = 1'b0;
  logic reset_b = 1'b0;
  always #5 clk = ~clk;

  packet_framer_if bus ();
  packet_framer_if bw ();

  packet_framer #(.NUM_STREAMS(16), .SEQ_INIT(32'h0000_0001)) dut (
    .clk(clk), .reset_b(reset_b), .bus(bus)
  );

  packet_framer #(.NUM_STREAMS(16), .SEQ_INIT(32'hFFFF_FFFF)) dut_w (
    .clk(clk), .reset_b(reset_b), .bus(bw)
  );

  int checks = 0;
  int failures = 0;

  logic [32:0] exp_q[$];
  logic [31:0] pay_q[$];
  logic [31:0] exp_seq[16];
  int          rdy_mode = 0;
  bit          gap_en = 1'b0;
  bit          pay_hold = 1'b0;
  bit          pay_fire_s = 1'b0;
  bit          stall_p = 1'b0;
  logic [31:0] data_p;
  logic        last_p;

  // payload source and downstream ready generator
  initial begin
    bus.pay_val = 1'b0;
    bus.pay_data = 32'h0;
    bus.dataOut_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (pay_fire_s && pay_q.size() > 0) void'(pay_q.pop_front());
      if (!(bus.pay_val && !pay_fire_s && pay_q.size() > 0)) begin
        if (pay_q.size() > 0 && !pay_hold && (!gap_en || $urandom_range(0, 1) == 1)) begin
          bus.pay_val = 1'b1;
          bus.pay_data = pay_q[0];
        end else begin
          bus.pay_val = 1'b0;
        end
      end
      bus.dataOut_ready = (rdy_mode == 0) ? 1'b1 : ~bus.dataOut_ready;
    end
  end

  // monitor: scoreboard pop on each transfer, stability during stalls
  always @(negedge clk) begin
    logic [32:0] e;
    pay_fire_s = bus.pay_val && bus.pay_ready;
    if (!reset_b) begin
      stall_p = 1'b0;
    end else begin
      if (stall_p) begin
        checks++;
        if (bus.dataOut_val !== 1'b1 || bus.dataOut !== data_p || bus.dataOut_last !== last_p) begin
          failures++;
          $display("FAIL stall_stable got val=%b data=%h last=%b exp val=1 data=%h last=%b",
                   bus.dataOut_val, bus.dataOut, bus.dataOut_last, data_p, last_p);
        end
      end
      if (bus.dataOut_val && bus.dataOut_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat got data=%h last=%b exp none", bus.dataOut, bus.dataOut_last);
        end else begin
          e = exp_q.pop_front();
          if ({bus.dataOut_last, bus.dataOut} !== e) begin
            failures++;
            $display("FAIL beat got last=%b data=%h exp last=%b data=%h",
                     bus.dataOut_last, bus.dataOut, e[32], e[31:0]);
          end
        end
      end
      stall_p = bus.dataOut_val && !bus.dataOut_ready;
      data_p = bus.dataOut;
      last_p = bus.dataOut_last;
    end
  end

  task automatic send(input logic [15:0] s, input logic [15:0] len, input bit skip,
                      input logic [31:0] pbase);
    bit          err;
    int          beats;
    int          n;
    logic [15:0] sl;
    logic [15:0] ll;
    logic [31:0] seq;
    logic [31:0] w0;
    logic [31:0] w;
    sl = s;
    ll = len;
    err = (sl >= 16'd16) || (!skip && ll < 16'd8);
    w0 = {ll[7:0], ll[15:8], sl[7:0], sl[15:8]};
    @(posedge clk);
    #1;
    bus.cmd_val = 1'b1;
    bus.cmd_stream = sl;
    bus.cmd_length = ll;
    bus.cmd_skip = skip;
    n = 0;
    @(negedge clk);
    while (bus.cmd_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL cmd_accept_timeout got cmd_ready=%b exp 1", bus.cmd_ready);
      @(posedge clk);
      #1;
      bus.cmd_val = 1'b0;
      return;
    end
    if (!err && !skip) begin
      beats = int'(ll[15:2]);
      seq = exp_seq[sl[3:0]];
      exp_q.push_back({1'b0, w0});
      exp_q.push_back({1'(beats == 2), seq[7:0], seq[15:8], seq[23:16], seq[31:24]});
      for (int i = 0; i < beats - 2; i++) begin
        w = pbase + 32'(i);
        exp_q.push_back({1'(i == beats - 3), w});
        pay_q.push_back(w);
      end
      exp_seq[sl[3:0]] = seq + 32'd1;
    end else if (!err) begin
      exp_seq[sl[3:0]] = exp_seq[sl[3:0]] + 32'd1;
    end
    @(posedge clk);
    #1;
    bus.cmd_val = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.cmd_err !== err) begin
      failures++;
      $display("FAIL cmd_err stream=%0d len=%0d got=%b exp=%b", sl, ll, bus.cmd_err, err);
    end
    checks++;
    if (!err && !skip) begin
      if (bus.dataOut_val !== 1'b1 || bus.dataOut !== w0) begin
        failures++;
        $display("FAIL word0_latency got val=%b data=%h exp val=1 data=%h",
                 bus.dataOut_val, bus.dataOut, w0);
      end
    end else if (bus.dataOut_val !== 1'b0) begin
      failures++;
      $display("FAIL no_output got val=%b exp 0", bus.dataOut_val);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout got pending=%0d exp 0", exp_q.size());
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b0 || bus.dataOut_val !== 1'b0 || bus.cmd_err !== 1'b0 ||
        bus.pay_ready !== 1'b0 || bus.dataOut !== 32'h0 || bus.dataOut_last !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b val=%b err=%b pr=%b data=%h last=%b exp all 0",
               bus.cmd_ready, bus.dataOut_val, bus.cmd_err, bus.pay_ready, bus.dataOut, bus.dataOut_last);
    end
    @(posedge clk);
    #1;
    reset_b = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_ready got=%b exp=1", bus.cmd_ready);
    end
  endtask

  task automatic test_basic();
    send(16'd12, 16'd20, 1'b0, 32'h0123_4562);
    send(16'd13, 16'd25, 1'b0, 32'hA000_0000);
    send(16'd12, 16'd20, 1'b0, 32'hB000_0000);
    wait_done();
  endtask

  task automatic test_skip();
    send(16'd12, 16'd0, 1'b1, 32'h0);
    send(16'd12, 16'd39, 1'b0, 32'hC000_0000);
    wait_done();
  endtask

  task automatic test_backpressure();
    rdy_mode = 1;
    gap_en = 1'b1;
    send(16'd5, 16'd36, 1'b0, 32'hD000_0000);
    send(16'd5, 16'd16, 1'b0, 32'hE000_0000);
    send(16'd6, 16'd8, 1'b0, 32'h0);
    wait_done();
    rdy_mode = 0;
    gap_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_errors();
    send(16'd16, 16'd20, 1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.cmd_err !== 1'b0) begin
      failures++;
      $display("FAIL err_pulse_width got=%b exp=0", bus.cmd_err);
    end
    send(16'd0, 16'd7, 1'b0, 32'h0);
    send(16'd20, 16'd8, 1'b1, 32'h0);
    send(16'd0, 16'd8, 1'b0, 32'h0);
    send(16'd0, 16'd11, 1'b0, 32'h0);
    wait_done();
  endtask

  task automatic test_wrap();
    logic [31:0] exp_w1;
    for (int k = 0; k < 2; k++) begin
      exp_w1 = (k == 0) ? 32'hFFFF_FFFF : 32'h0000_0000;
      @(posedge clk);
      #1;
      bw.cmd_val = 1'b1;
      bw.cmd_stream = 16'd3;
      bw.cmd_length = 16'd8;
      bw.cmd_skip = 1'b0;
      @(negedge clk);
      checks++;
      if (bw.cmd_ready !== 1'b1) begin
        failures++;
        $display("FAIL wrap_ready got=%b exp=1", bw.cmd_ready);
      end
      @(posedge clk);
      #1;
      bw.cmd_val = 1'b0;
      @(negedge clk);
      checks++;
      if (bw.dataOut_val !== 1'b1 || bw.dataOut !== 32'h0800_0300) begin
        failures++;
        $display("FAIL wrap_word0 got val=%b data=%h exp val=1 data=08000300", bw.dataOut_val, bw.dataOut);
      end
      @(negedge clk);
      checks++;
      if (bw.dataOut_val !== 1'b1 || bw.dataOut !== exp_w1 || bw.dataOut_last !== 1'b1) begin
        failures++;
        $display("FAIL wrap_word1 got val=%b data=%h last=%b exp val=1 data=%h last=1",
                 bw.dataOut_val, bw.dataOut, bw.dataOut_last, exp_w1);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_pay();
    pay_hold = 1'b1;
    send(16'd3, 16'd16, 1'b0, 32'h5500_0000);
    repeat (6) @(negedge clk);
    checks++;
    if (exp_q.size() != 2) begin
      failures++;
      $display("FAIL header_before_stall got pending=%0d exp 2", exp_q.size());
    end
    @(posedge clk);
    #2;
    reset_b = 1'b0;
    #1;
    checks++;
    if (bus.dataOut_val !== 1'b0 || bus.cmd_ready !== 1'b0 || bus.pay_ready !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got val=%b rdy=%b pr=%b exp 0 0 0",
               bus.dataOut_val, bus.cmd_ready, bus.pay_ready);
    end
    exp_q.delete();
    pay_q.delete();
    pay_hold = 1'b0;
    for (int i = 0; i < 16; i++) exp_seq[i] = 32'h0000_0001;
    repeat (2) @(posedge clk);
    #1;
    reset_b = 1'b1;
    @(negedge clk);
    send(16'd3, 16'd12, 1'b0, 32'h6600_0000);
    wait_done();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) exp_seq[i] = 32'h0000_0001;
    bus.cmd_val = 1'b0;
    bus.cmd_stream = 16'h0;
    bus.cmd_length = 16'h0;
    bus.cmd_skip = 1'b0;
    bw.cmd_val = 1'b0;
    bw.cmd_stream = 16'h0;
    bw.cmd_length = 16'h0;
    bw.cmd_skip = 1'b0;
    bw.pay_val = 1'b0;
    bw.pay_data = 32'h0;
    bw.dataOut_ready = 1'b1;
    test_reset();
    test_basic();
    test_skip();
    test_backpressure();
    test_errors();
    test_wrap();
    test_reset_mid_pay();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/packet_framer.md
Name: packet_framer

Overview:
- Upstream stage of `parser`: turns per-packet commands plus a raw payload word stream into framed 32-bit packet beats on the parser's input interface.
- Keeps one sequence counter per stream and prepends the 8-byte header (length, stream, sequence), all little-endian.
- A skip command consumes a sequence number without sending anything, so packet loss can be injected deliberately.

Parameters:
- NUM_STREAMS, 16: number of per-stream sequence counters; valid stream IDs are 0..NUM_STREAMS-1.
- SEQ_INIT, 32'h00000001: reset value of every sequence counter.

Ports:
- clk  in  1  clock.
- reset_b  in  1  reset, asynchronous, active-low.
- cmd_val  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_val && cmd_ready.
- cmd_stream  in  16  stream ID.
- cmd_length  in  16  total packet bytes, including the 8-byte header.
- cmd_skip  in  1  1 = advance this stream's sequence number, emit nothing.
- cmd_err  out  1  one-cycle pulse: command rejected.
- pay_data  in  32  payload word.
- pay_val  in  1  payload valid.
- pay_ready  out  1  payload accepted when pay_val && pay_ready.
- dataOut  out  32  framed beat (drives parser dataIn).
- dataOut_val  out  1  beat valid.
- dataOut_ready  in  1  downstream ready.
- dataOut_last  out  1  final beat of packet (drives parser dataIN_last).

Behaviour:
- Reset (async, reset_b=0):
  - all outputs 0; FSM to IDLE;
  - every sequence counter set to SEQ_INIT;
  - any in-flight packet is abandoned: no completion of the packet and no sequence increment.
- Beat count: beats = cmd_length>>2. Trailing (cmd_length mod 4) bytes are never sent. Payload beats = beats-2.
- Header word encoding:
  - word0 = {len[7:0], len[15:8], stream[7:0], stream[15:8]};
  - word1 = {seq[7:0], seq[15:8], seq[23:16], seq[31:24]}.
- FSM states: IDLE, HDR0, HDR1, PAY.
- IDLE:
  - cmd_ready=1, all other handshake outputs 0.
  - On accept, latch stream, length and the current seq of that stream.
  - Error case: cmd_stream>=NUM_STREAMS, or (!cmd_skip && cmd_length<8). Pulse cmd_err next cycle, stay IDLE, change no counter.
  - Skip case: cmd_skip=1 and stream valid. Counter[stream]+=1 one cycle later, stay IDLE; cmd_length is ignored.
  - Otherwise go to HDR0.
- Latency: a command accepted at edge N presents word0 with dataOut_val=1 after edge N.
- HDR0:
  - dataOut=word0, val=1, last=0.
  - On dataOut_ready go to HDR1.
- HDR1:
  - dataOut=word1, val=1, last=(beats==2).
  - On dataOut_ready: counter[stream]+=1; go to IDLE if beats==2, else PAY.
- PAY:
  - Combinational pass-through: dataOut=pay_data, dataOut_val=pay_val, pay_ready=dataOut_ready.
  - A payload beat counter decrements on each transfer.
  - dataOut_last=1 on the final payload beat; after its transfer go to IDLE.
  - cmd_ready=0 in HDR0, HDR1 and PAY.
- Stability: while dataOut_val && !dataOut_ready, dataOut and dataOut_last hold stable in HDR0/HDR1. In PAY, stability is inherited from the payload source.
- Sequence arithmetic: 32-bit modulo; 0xFFFFFFFF+1 = 0x00000000.
- Stream independence: counters are independent per stream; a skip or send on one stream never alters another.
- Back-to-back: IDLE lasts at least one cycle between packets. Max throughput is beats+1 cycles per packet.
- Sequence increment timing: the counter increments exactly once per sent packet, at the word1 transfer, even if the payload is later stalled indefinitely.

Test Plan:
- Send (stream 12, len 20), payload 0x01234562..64, ready=1 → beats 0x14000C00, 0x01000000, 0x01234562, 0x01234563, 0x01234564; last only on beat 5; word0 one cycle after cmd accept.
- Then (stream 13, len 25) → 6 beats, word0 0x19000D00, word1 0x01000000 (independent counter); a following (12, len 20) gives word1 0x02000000.
- Skip on stream 12, then (12, len 39) → 9 beats, word0 0x27000C00, word1 0x04000000; the connected parser must assert packetLost.
- Backpressure: dataOut_ready toggling 1010…, pay_val gapped → each beat transferred exactly once, in order; dataOut stable during stalls; no extra or missing last.
- Errors and edges:
  - (stream 16, len 20) → cmd_err pulse, no dataOut_val, counters unchanged.
  - (stream 0, len 7) → cmd_err.
  - (0, len 8) → two beats, last on word1.
  - (0, len 11) → also two beats.
- Wrap and reset:
  - With SEQ_INIT=0xFFFFFFFF, two packets on stream 3 → word1 0xFFFFFFFF then 0x00000000.
  - reset_b low mid-PAY → dataOut_val=0 immediately; after release, stream 3 restarts at SEQ_INIT.
